matrix_dot_unit: RTL and testbench

- Computes the dot product of two 16-element vectors of unsigned 8-bit values: c = sum over i of a[i]*b[i].
- Result is 16 bits; wraps modulo 2^16 by default.
- Sequential multiply-accumulate engine started by a start pulse, with a sticky done flag.
- Sits as a compute leaf inside the NPU datapath, driven by a controller that loads the operands and then pulses start.

---
 rtl/matrix_dot_unit_if.sv | 15 +
 rtl/matrix_dot_unit.sv | 91 +++++++++
 tb/tb_matrix_dot_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/matrix_dot_unit_if.sv
// Operand/result bundle between the NPU controller (master) and matrix_dot_unit (slave).
interface matrix_dot_unit_if #(
    parameter int unsigned N  = 16,
    parameter int unsigned DW = 8,
    parameter int unsigned OW = 16
);
    logic          start;
    logic [DW-1:0] a [0:N-1];
    logic [DW-1:0] b [0:N-1];
    logic [OW-1:0] c;
    logic          done;

    modport master (output start, output a, output b, input c, input done);
    modport slave  (input start, input a, input b, output c, output done);
endinterface

// File: rtl/matrix_dot_unit.sv
// Sequential unsigned dot product c = sum(a[i]*b[i]), LANES products per cycle, sticky done.
// Optional MATRIX_DOT_SATURATE_EN clamps c to 2^OW-1 instead of wrapping.
module matrix_dot_unit #(
    parameter int unsigned N     = 16,
    parameter int unsigned DW    = 8,
    parameter int unsigned OW    = 16,
    parameter int unsigned LANES = 1
) (
    input logic             clk,
    input logic             rst,
    matrix_dot_unit_if.slave bus
);
    localparam int unsigned AW = 2 * DW + $clog2(N);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(N - LANES);

    typedef enum logic [1:0] {StIdle, StRun, StFinish, StDone} state_e;

    state_e        state;
    logic [DW-1:0] a_q [N];
    logic [DW-1:0] b_q [N];
    logic [AW-1:0] acc;
    logic [IW-1:0] idx;
    logic [OW-1:0] c_q;
    logic          done_q;
    logic [AW-1:0] lane_sum;
    logic [OW-1:0] result;
    logic          accept;

    assign accept = !rst && bus.start && (state == StIdle || state == StDone);

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            lane_sum = lane_sum + AW'(a_q[idx + IW'(l)]) * AW'(b_q[idx + IW'(l)]);
        end
    end

    always_comb begin
`ifdef MATRIX_DOT_SATURATE_EN
        result = (acc > AW'({OW{1'b1}})) ? '1 : acc[OW-1:0];
`else
        result = acc[OW-1:0];
`endif
    end

    // Operand capture needs no reset; it is only consumed after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= bus.a;
            b_q <= bus.b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= StIdle;
            acc    <= '0;
            idx    <= '0;
            c_q    <= '0;
            done_q <= 1'b0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (bus.start) begin
                        acc    <= '0;
                        idx    <= '0;
                        done_q <= 1'b0;
                        state  <= StRun;
                    end
                end
                StRun: begin
                    acc <= acc + lane_sum;
                    idx <= idx + IW'(LANES);
                    if (idx == LastIdx) begin
                        state <= StFinish;
                    end
                end
                StFinish: begin
                    c_q    <= result;
                    done_q <= 1'b1;
                    state  <= StDone;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.c    = c_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_matrix_dot_unit.sv
// Self-checking bench for matrix_dot_unit: cycle-level reference model plus directed and random cases.
module tb_matrix_dot_unit;
    localparam int N     = 16;
    localparam int DW    = 8;
    localparam int OW    = 16;
    localparam int LANES = 1;
    localparam int K     = N / LANES;

    typedef logic [DW-1:0] vec_t [N];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_dot_unit_if #(.N(N), .DW(DW), .OW(OW)) bus ();

    matrix_dot_unit #(.N(N), .DW(DW), .OW(OW), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [OW-1:0] dot_ref(input vec_t x, input vec_t y);
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(x[i]) * longint'(y[i]);
`ifdef MATRIX_DOT_SATURATE_EN
        if (s > 65535) s = 65535;
`endif
        return OW'(s);
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Reference: a start seen while not busy launches a job whose result appears K+1 edges later.
    int          busy_left = 0;
    logic        model_ok  = 1'b0;
    logic        exp_done  = 1'b0;
    logic [OW-1:0] exp_c   = '0;
    logic [OW-1:0] pend_c  = '0;

    always @(posedge clk) begin
        if (rst) begin
            model_ok  <= 1'b1;
            busy_left <= 0;
            exp_done  <= 1'b0;
            exp_c     <= '0;
        end else if (model_ok) begin
            if (busy_left == 0) begin
                if (bus.start) begin
                    pend_c    <= dot_ref(bus.a, bus.b);
                    exp_done  <= 1'b0;
                    busy_left <= K + 1;
                end
            end else if (busy_left == 1) begin
                exp_c     <= pend_c;
                exp_done  <= 1'b1;
                busy_left <= 0;
            end else begin
                busy_left <= busy_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            checks++;
            if (bus.done !== exp_done || bus.c !== exp_c) begin
                errors++;
                $display("FAIL cycle_compare t=%0t done=%b c=%0d expected done=%b c=%0d",
                         $time, bus.done, bus.c, exp_done, exp_c);
            end
        end
    end

    task automatic set_ops(input vec_t x, input vec_t y);
        bus.a = x;
        bus.b = y;
    endtask

    // Returns at the negedge right after the accepting posedge.
    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int lat = 0;
        while (!bus.done && lat < K + 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_done"}, bus.done, 1);
        if (exp_lat >= 0) check({name, "_lat"}, lat, exp_lat);
    endtask

    vec_t zeros, ones, ramp, fulls, va, vb;
    logic [OW-1:0] full_exp;

    initial begin
        bus.start = 1'b0;
        for (int i = 0; i < N; i++) begin
            zeros[i] = '0;
            ones[i]  = 8'd1;
            ramp[i]  = DW'(i);
            fulls[i] = 8'hFF;
        end
        set_ops(zeros, zeros);
`ifdef MATRIX_DOT_SATURATE_EN
        full_exp = 16'd65535;
`else
        full_exp = 16'd57360;
`endif

        check("model_zero", dot_ref(zeros, zeros), 0);
        check("model_ramp_ones", dot_ref(ramp, ones), 120);
        check("model_ramp_sq", dot_ref(ramp, ramp), 1240);
        check("model_full", dot_ref(fulls, fulls), full_exp);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_c", bus.c, 0);
        check("reset_done", bus.done, 0);

        set_ops(zeros, zeros);
        pulse_start();
        wait_done("zeros", K + 1);
        check("zeros_c", bus.c, 0);

        set_ops(ramp, ones);
        pulse_start();
        wait_done("ramp_ones", K + 1);
        check("ramp_ones_c", bus.c, 120);

        set_ops(ramp, ramp);
        pulse_start();
        check("reaccept_done_clear", bus.done, 0);
        check("reaccept_c_held", bus.c, 120);
        wait_done("ramp_sq", K + 1);
        check("ramp_sq_c", bus.c, 1240);

        set_ops(fulls, fulls);
        pulse_start();
        wait_done("full", K + 1);
        check("full_c", bus.c, full_exp);

        // Second start during RUN with new operands must be ignored.
        set_ops(ramp, ones);
        pulse_start();
        repeat (4) @(negedge clk);
        set_ops(fulls, fulls);
        pulse_start();
        wait_done("ignore", -1);
        check("ignore_c", bus.c, 120);
        repeat (5) @(negedge clk);
        check("ignore_sticky_done", bus.done, 1);
        check("ignore_sticky_c", bus.c, 120);

        // Reset mid-RUN discards the job.
        set_ops(ramp, ramp);
        pulse_start();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("midrst_done", bus.done, 0);
        check("midrst_c", bus.c, 0);
        repeat (K + 4) @(negedge clk);
        check("midrst_idle_done", bus.done, 0);
        set_ops(ramp, ramp);
        pulse_start();
        wait_done("after_rst", K + 1);
        check("after_rst_c", bus.c, 1240);

        // Start held for several cycles is accepted only once.
        set_ops(ones, ramp);
        @(negedge clk) bus.start = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        wait_done("held", -1);
        check("held_c", bus.c, 120);

        for (int t = 0; t < 1000; t++) begin
            for (int i = 0; i < N; i++) begin
                va[i] = (t % 8 == 0) ? 8'hFF : DW'($urandom_range(0, 255));
                vb[i] = (t % 8 == 0) ? DW'($urandom_range(200, 255)) : DW'($urandom_range(0, 255));
            end
            set_ops(va, vb);
            pulse_start();
            // Operands may change freely after capture.
            set_ops(ones, ones);
            wait_done("rand", K + 1);
            check("rand_c", bus.c, dot_ref(va, vb));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
